// File: rtl/plot_stream_decoder.sv
`timescale 1ns/1ps
// plot_stream_decoder
//   Listens to the pixel-write stream (x, y, colour) that the playfield plotter
//   sends to the VGA adapter and rebuilds the playfield word from it. The word
//   holds the runner height and 79 obstacle heights. A new word is published
//   once per complete, well-formed frame. Any write that breaks the plot order
//   or the pixel format raises a one-cycle error pulse and abandons the frame.
//
// Ports
//   CLOCK_50     in   1    system clock, all state changes on the rising edge
//   resetn       in   1    synchronous active-low reset
//   pix_valid    in   1    qualifies pix_x / pix_y / pix_colour this cycle
//   pix_x        in   8    pixel x
//   pix_y        in   7    pixel y
//   pix_colour   in   3    pixel colour
//   frame        out  160  last good frame: [159:158] runner height,
//                          [157-2i:156-2i] obstacle column i (x = COL_X0+2i)
//   frame_valid  out  1    one-cycle pulse when frame is updated
//   runner_h     out  2    copy of frame[159:158]
//   collision    out  1    runner on the ground with a non-empty column 0
//   err          out  1    one-cycle pulse on a stream violation
//
// Stream handshake: a write is consumed on a rising edge where pix_valid=1.
// There is no back-pressure; pix_valid=0 cycles simply pause the decoder.
module plot_stream_decoder #(
   parameter int          BASE_Y   = 120,
   parameter int          COL_X0   = 2,
   parameter int          N_COLS   = 79,
   parameter logic [2:0]  C_BASE   = 3'b110,
   parameter logic [2:0]  C_RUNNER = 3'b101,
   parameter logic [2:0]  C_OBST   = 3'b010
) (
   input  logic                  CLOCK_50,
   input  logic                  resetn,
   input  logic                  pix_valid,
   input  logic [7:0]            pix_x,
   input  logic [6:0]            pix_y,
   input  logic [2:0]            pix_colour,
   output logic [2*N_COLS+1:0]   frame,
   output logic                  frame_valid,
   output logic [1:0]            runner_h,
   output logic                  collision,
   output logic                  err
);

   localparam int          OBST_W   = 2 * N_COLS;
   localparam logic [6:0]  BASE_Y7  = 7'(BASE_Y);
   localparam logic [7:0]  COL_X0_8 = 8'(COL_X0);
   localparam logic [6:0]  LAST_COL = 7'(N_COLS - 1);

   typedef enum logic [1:0] {HUNT, RUNNER, OBST} state_t;

   state_t              state, state_n;
   logic [4:0]          k, k_n;            // runner write index 0..19
   logic [6:0]          i, i_n;            // obstacle column index
   logic [2:0]          c, c_n;            // write index inside a column
   logic [8:0]          rmask, rmask_n;    // bit j: runner colour at offset j+1 in x=0
   logic [2:0]          omask, omask_n;    // bit j: obstacle colour at offset j+1, first half
   logic [1:0]          sh_h, sh_h_n;      // shadow runner height
   logic [OBST_W-1:0]   obst_sr, obst_n;   // shadow obstacle word, column 0 ends at the top
   logic [OBST_W+1:0]   frame_n;
   logic                fv_n, coll_n, err_n;

   // Checks the runner column mask: returns {ok, h}. The runner occupies
   // offsets max(1,2h)..2h+3 where h is half the lowest runner offset.
   function automatic logic [2:0] runner_check(input logic [8:0] m);
      logic       found;
      logic [3:0] f, h4, lo, hi, off;
      logic [8:0] e;
      found = 1'b0;
      f     = 4'd0;
      for (int j = 8; j >= 0; j--) begin
         if (m[j]) begin
            found = 1'b1;
            f     = 4'(j + 1);
         end
      end
      h4 = f >> 1;
      lo = (h4 == 4'd0) ? 4'd1 : (h4 << 1);
      hi = (h4 << 1) + 4'd3;
      e  = '0;
      for (int j = 0; j < 9; j++) begin
         off  = 4'(j + 1);
         e[j] = (off >= lo) && (off <= hi);
      end
      return {found && (h4 < 4'd4) && (e == m), h4[1:0]};
   endfunction

   logic        is_start, is_blank, is_run, is_obst;
   logic        k_lt10;
   logic [3:0]  r_off;
   logic        r_ok;
   logic [2:0]  r_chk;
   logic [1:0]  o_off;
   logic        o_ok;
   logic [2:0]  o_m;
   logic        thermo;
   logic [1:0]  o_v;

   always_comb begin
      is_start = (pix_x == 8'd0) && (pix_y == BASE_Y7);
      is_blank = (pix_colour == 3'b000);
      is_run   = (pix_colour == C_RUNNER);
      is_obst  = (pix_colour == C_OBST);

      // Runner offset is k mod 10; for k=10..19, adding 6 wraps k[3:0] onto 0..9.
      k_lt10 = (k < 5'd10);
      r_off  = k_lt10 ? k[3:0] : (k[3:0] + 4'd6);
      r_chk  = runner_check({is_run, rmask[7:0]});
      r_ok   = (pix_x == (k_lt10 ? 8'd0 : 8'd1)) && (pix_y == BASE_Y7 - {3'b000, r_off});
      if (r_off == 4'd0)
         r_ok = r_ok && (pix_colour == C_BASE);
      else if (k_lt10)
         r_ok = r_ok && (is_run || is_blank);
      else
         r_ok = r_ok && (is_run || is_blank) && (is_run == rmask[r_off - 4'd1]);
      if (k == 5'd9)
         r_ok = r_ok && r_chk[2];

      o_off  = c[1:0];
      o_m    = {is_obst, omask[1:0]};
      thermo = (o_m == 3'b000) || (o_m == 3'b001) || (o_m == 3'b011) || (o_m == 3'b111);
      o_v    = o_m[2] ? 2'd3 : (o_m[1] ? 2'd2 : (o_m[0] ? 2'd1 : 2'd0));
      o_ok   = (pix_x == COL_X0_8 + {i, 1'b0} + {7'd0, c[2]}) &&
               (pix_y == BASE_Y7 - {5'd0, o_off});
      if (o_off == 2'd0)
         o_ok = o_ok && (pix_colour == C_BASE);
      else if (!c[2])
         o_ok = o_ok && (is_obst || is_blank);
      else
         o_ok = o_ok && (is_obst || is_blank) && (is_obst == omask[o_off - 2'd1]);
      if (c == 3'd3)
         o_ok = o_ok && thermo;
   end

   always_comb begin
      state_n = state;
      k_n     = k;
      i_n     = i;
      c_n     = c;
      rmask_n = rmask;
      omask_n = omask;
      sh_h_n  = sh_h;
      obst_n  = obst_sr;
      frame_n = frame;
      coll_n  = collision;
      fv_n    = 1'b0;
      err_n   = 1'b0;

      if (pix_valid) begin
         unique case (state)
            HUNT: begin
               if (is_start) begin
                  state_n = RUNNER;
                  k_n     = 5'd1;
                  rmask_n = '0;
               end
            end
            RUNNER: begin
               if (!r_ok) begin
                  err_n = 1'b1;
                  // The offending write may itself be the start of a new frame.
                  state_n = is_start ? RUNNER : HUNT;
                  k_n     = 5'd1;
                  rmask_n = '0;
               end else begin
                  if (k_lt10 && r_off != 4'd0)
                     rmask_n[r_off - 4'd1] = is_run;
                  if (k == 5'd9)
                     sh_h_n = r_chk[1:0];
                  if (k == 5'd19) begin
                     state_n = OBST;
                     i_n     = 7'd0;
                     c_n     = 3'd0;
                     omask_n = '0;
                  end else begin
                     k_n = k + 5'd1;
                  end
               end
            end
            OBST: begin
               if (!o_ok) begin
                  err_n   = 1'b1;
                  state_n = is_start ? RUNNER : HUNT;
                  k_n     = 5'd1;
                  rmask_n = '0;
               end else begin
                  if (!c[2] && o_off != 2'd0)
                     omask_n[o_off - 2'd1] = is_obst;
                  if (c == 3'd3)
                     obst_n = {obst_sr[OBST_W-3:0], o_v};
                  if (c == 3'd7) begin
                     c_n     = 3'd0;
                     omask_n = '0;
                     if (i == LAST_COL) begin
                        // The last column was shifted in at its c=3 write.
                        frame_n = {sh_h, obst_sr};
                        coll_n  = (sh_h == 2'd0) && (obst_sr[OBST_W-1 -: 2] != 2'd0);
                        fv_n    = 1'b1;
                        state_n = HUNT;
                     end else begin
                        i_n = i + 7'd1;
                     end
                  end else begin
                     c_n = c + 3'd1;
                  end
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state       <= HUNT;
         k           <= '0;
         i           <= '0;
         c           <= '0;
         rmask       <= '0;
         omask       <= '0;
         sh_h        <= '0;
         obst_sr     <= '0;
         frame       <= '0;
         frame_valid <= 1'b0;
         collision   <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= state_n;
         k           <= k_n;
         i           <= i_n;
         c           <= c_n;
         rmask       <= rmask_n;
         omask       <= omask_n;
         sh_h        <= sh_h_n;
         obst_sr     <= obst_n;
         frame       <= frame_n;
         frame_valid <= fv_n;
         collision   <= coll_n;
         err         <= err_n;
      end
   end

   assign runner_h = frame[OBST_W+1 -: 2];

endmodule
